hex_display_arbiter: RTL

//  Shares the two 32-bit hex-display PIO outputs between the PCIe host (PIO words) and a local source (switch-derived words).

---
 rtl/hex_display_arbiter_pkg.sv | 15 +
 rtl/hex_display_arbiter_debounce.sv | 44 ++++
 rtl/hex_display_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hex_display_arbiter_pkg.sv
// Shared types and constants for the hex display arbiter (owner encoding, blank word, status layout).
package hex_arb_pkg;

  typedef enum logic [1:0] {
    OWN_LOCAL  = 2'd0,
    OWN_HOST   = 2'd1,
    OWN_LOCKED = 2'd2
  } owner_e;

  localparam logic [31:0] HEX_BLANK = 32'hFFFF_FFFF;

  localparam int STATUS_OWNER_LSB = 0;
  localparam int STATUS_DROP_LSB  = 8;

endpackage

// File: rtl/hex_display_arbiter_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, one-cycle press pulse
// on each debounced 1->0 transition of the active-low button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      // Level follows the synchronised input only after DEBOUNCE_CYCLES differing samples in a row.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Arbitrates the two hex-display words between the PCIe host and the local source, with a
// button-toggled LOCKED mode. Define HEXARB_BLINK_EN to blink the display while LOCKED.
module hex_display_arbiter
  import hex_arb_pkg::*;
#(
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
`ifdef HEXARB_BLINK_EN
  ,
  parameter int BLINK_DIV       = 12_500_000
`endif
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] host_hex_lo_i,
  input  logic [31:0] host_hex_hi_i,
  input  logic [31:0] local_hex_lo_i,
  input  logic [31:0] local_hex_hi_i,
  input  logic        lock_btn_n_i,
  output logic [31:0] hex_lo_o,
  output logic [31:0] hex_hi_o,
  output logic [1:0]  owner_o,
  output logic        host_grant_pulse_o,
  output logic [31:0] status_o
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  owner_e        state;
  logic [HW-1:0] hold_cnt;
  logic [31:0]   host_lo_q;
  logic [31:0]   host_hi_q;
  logic          prime;
  logic          press;
  logic          activity;
  logic [7:0]    drop_cnt;
  logic          locked_visible;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .btn_n (lock_btn_n_i),
    .press (press)
  );

  // The first cycle after reset compares against the reset value of the capture registers,
  // so prime masks it to keep reset from looking like a host write.
  assign activity = prime && ({host_hex_hi_i, host_hex_lo_i} != {host_hi_q, host_lo_q});

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      host_lo_q <= '0;
      host_hi_q <= '0;
      prime     <= 1'b0;
    end else begin
      host_lo_q <= host_hex_lo_i;
      host_hi_q <= host_hex_hi_i;
      prime     <= 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state              <= OWN_LOCAL;
      hold_cnt           <= '0;
      drop_cnt           <= '0;
      host_grant_pulse_o <= 1'b0;
    end else begin
      host_grant_pulse_o <= 1'b0;
      if (press) begin
        // A press takes priority; any host activity in the same cycle is discarded.
        case (state)
          OWN_LOCAL:  state <= OWN_LOCKED;
          OWN_HOST:   state <= OWN_LOCKED;
          OWN_LOCKED: state <= OWN_LOCAL;
          default:    state <= OWN_LOCAL;
        endcase
      end else begin
        case (state)
          OWN_LOCAL: begin
            if (activity) begin
              state              <= OWN_HOST;
              hold_cnt           <= HOLD_LOAD;
              host_grant_pulse_o <= 1'b1;
            end
          end
          OWN_HOST: begin
            if (activity) begin
              hold_cnt <= HOLD_LOAD;
            end else if (hold_cnt == '0) begin
              state <= OWN_LOCAL;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          OWN_LOCKED: begin
            if (activity && (drop_cnt != 8'hFF)) begin
              drop_cnt <= drop_cnt + 1'b1;
            end
          end
          default: state <= OWN_LOCAL;
        endcase
      end
    end
  end

`ifdef HEXARB_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_vis;

  // Held at its start value outside LOCKED so every LOCKED entry begins with a visible phase.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (state != OWN_LOCKED) begin
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      blink_vis <= ~blink_vis;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign locked_visible = blink_vis;
`else
  assign locked_visible = 1'b1;
`endif

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      hex_lo_o <= HEX_BLANK;
      hex_hi_o <= HEX_BLANK;
    end else if (state == OWN_HOST) begin
      hex_lo_o <= host_lo_q;
      hex_hi_o <= host_hi_q;
    end else if ((state == OWN_LOCKED) && !locked_visible) begin
      hex_lo_o <= HEX_BLANK;
      hex_hi_o <= HEX_BLANK;
    end else begin
      hex_lo_o <= local_hex_lo_i;
      hex_hi_o <= local_hex_hi_i;
    end
  end

  assign owner_o = state;

  always_comb begin
    status_o = '0;
    status_o[STATUS_OWNER_LSB +: 2] = state;
    status_o[STATUS_DROP_LSB +: 8]  = drop_cnt;
  end

endmodule
